// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes, debounces and pulse-encodes active-low push-buttons
module key_conditioner #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 100000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] hold_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    // The sample arriving on the edge where the count equals DB_LAST is the
    // DEBOUNCE_CYCLES-th unbroken one, so the change is accepted on that edge.
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DB_ONE    = CW'(1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        logic          meta_q, s_q;
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [HW-1:0] timer_q, timer_d;
        logic          press_q, release_q, hold_q;
        logic          held_now, hold_fire;

        // Two-flop synchronizer on the inverted key (1 = pressed)
        always_ff @(posedge clk) begin
            if (!rst) begin
                meta_q <= 1'b0;
                s_q    <= 1'b0;
            end else begin
                meta_q <= ~key_n[i];
                s_q    <= meta_q;
            end
        end

        // Debounce next-state and qualification counter
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE: if (s_q) begin
                    state_d = (DEBOUNCE_CYCLES == 1) ? PRESSED : PRESS_WAIT;
                    cnt_d   = (DEBOUNCE_CYCLES == 1) ? '0 : DB_ONE;
                end
                PRESS_WAIT: begin
                    state_d = !s_q ? IDLE : (cnt_q == DB_LAST) ? PRESSED : PRESS_WAIT;
                    cnt_d   = (!s_q || cnt_q == DB_LAST) ? '0 : cnt_q + DB_ONE;
                end
                PRESSED: if (!s_q) begin
                    state_d = (DEBOUNCE_CYCLES == 1) ? IDLE : RELEASE_WAIT;
                    cnt_d   = (DEBOUNCE_CYCLES == 1) ? '0 : DB_ONE;
                end
                RELEASE_WAIT: begin
                    state_d = s_q ? PRESSED : (cnt_q == DB_LAST) ? IDLE : RELEASE_WAIT;
                    cnt_d   = (s_q || cnt_q == DB_LAST) ? '0 : cnt_q + DB_ONE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Hold timer: restarts on a fresh press, saturates so it fires once per press
        always_comb begin
            held_now  = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
            timer_d   = (state_d == IDLE || (state_d == PRESSED && !held_now)) ? '0 :
                        (held_now && timer_q != HOLD_MAX) ? timer_q + HOLD_ONE : timer_q;
            hold_fire = held_now && state_d != IDLE && timer_q == HOLD_LAST;
        end

        // State, counters and registered strobes
        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                timer_q   <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                hold_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                timer_q   <= timer_d;
                press_q   <= state_d == PRESSED && !held_now;
                release_q <= held_now && state_d == IDLE;
                hold_q    <= hold_fire;
            end
        end

        assign pressed[i]       = held_now;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign hold_pulse[i]    = hold_q;
    end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed checks of debounce, pulse timing, hold and reset behaviour
module tb_key_conditioner;
    localparam int D = 4;
    localparam int H = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] key_n = 2'b11;
    logic [1:0] pressed, press_pulse, release_pulse, hold_pulse;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int pc[2] = '{0, 0};
    int pl[2] = '{-1, -1};
    int rc[2] = '{0, 0};
    int rl[2] = '{-1, -1};
    int hc[2] = '{0, 0};
    int hl[2] = '{-1, -1};
    int excl = 0;
    int bp[2], br[2], bh[2];

    key_conditioner #(.NUM_KEYS(2), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst(rst), .key_n(key_n), .pressed(pressed),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .hold_pulse(hold_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every strobe with the edge number it followed
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (press_pulse[c] === 1'b1) begin
                pc[c] <= pc[c] + 1;
                pl[c] <= cyc;
            end
            if (release_pulse[c] === 1'b1) begin
                rc[c] <= rc[c] + 1;
                rl[c] <= cyc;
            end
            if (hold_pulse[c] === 1'b1) begin
                hc[c] <= hc[c] + 1;
                hl[c] <= cyc;
            end
            if (press_pulse[c] === 1'b1 && (release_pulse[c] === 1'b1 || hold_pulse[c] === 1'b1))
                excl <= excl + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        bp = pc;
        br = rc;
        bh = hc;
    endtask

    function automatic int outs();
        return int'({pressed, press_pulse, release_pulse, hold_pulse});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, t1;
        // reset
        step(3);
        check("reset_outs", outs(), 0);
        key_n = 2'b10;
        step(3);
        check("reset_no_pulse", pc[0], 0);
        check("reset_outs_key", outs(), 0);
        rst = 1'b1;
        t0 = cyc;
        step(10);
        check("reset_press_time", pl[0], t0 + 6);
        check("reset_press_cnt", pc[0], 1);
        check("reset_pressed", int'(pressed), 1);
        t1 = cyc;
        key_n = 2'b11;
        step(10);
        check("reset_rel_time", rl[0], t1 + 6);
        check("reset_rel_pressed", int'(pressed), 0);
        // clean press and release, held past the hold time
        snap();
        t0 = cyc;
        key_n = 2'b10;
        step(30);
        check("clean_press_time", pl[0], t0 + 6);
        check("clean_press_cnt", pc[0] - bp[0], 1);
        check("clean_pressed", int'(pressed), 1);
        check("clean_hold_time", hl[0], t0 + 26);
        t1 = cyc;
        key_n = 2'b11;
        step(10);
        check("clean_rel_time", rl[0], t1 + 6);
        check("clean_rel_cnt", rc[0] - br[0], 1);
        check("clean_rel_pressed", int'(pressed), 0);
        // bounce then stable
        snap();
        t0 = cyc;
        key_n = 2'b10;
        step(2);
        key_n = 2'b11;
        step(1);
        key_n = 2'b10;
        step(12);
        check("bounce_press_time", pl[0], t0 + 9);
        check("bounce_press_cnt", pc[0] - bp[0], 1);
        key_n = 2'b11;
        step(10);
        // repeated 3-low/1-high never qualifies
        snap();
        for (int r = 0; r < 5; r++) begin
            key_n = 2'b10;
            step(3);
            key_n = 2'b11;
            step(1);
        end
        step(6);
        check("chatter_press_cnt", pc[0] - bp[0], 0);
        check("chatter_pressed", int'(pressed), 0);
        // long press on key 1
        snap();
        t0 = cyc;
        key_n = 2'b01;
        step(46);
        check("long_press_time", pl[1], t0 + 6);
        check("long_hold_time", hl[1], t0 + 26);
        check("long_hold_cnt", hc[1] - bh[1], 1);
        key_n = 2'b11;
        step(10);
        // release before the hold time
        snap();
        key_n = 2'b01;
        step(16);
        t1 = cyc;
        key_n = 2'b11;
        step(20);
        check("short_hold_cnt", hc[1] - bh[1], 0);
        check("short_rel_time", rl[1], t1 + 6);
        // short release glitch during the hold
        snap();
        t0 = cyc;
        key_n = 2'b01;
        step(16);
        key_n = 2'b11;
        step(2);
        key_n = 2'b01;
        step(20);
        check("glitch_hold_time", hl[1], t0 + 26);
        check("glitch_hold_cnt", hc[1] - bh[1], 1);
        check("glitch_rel_cnt", rc[1] - br[1], 0);
        check("glitch_pressed", int'(pressed), 2);
        key_n = 2'b11;
        step(10);
        // simultaneous keys
        snap();
        t0 = cyc;
        key_n = 2'b00;
        step(10);
        check("simul_press0", pl[0], t0 + 6);
        check("simul_press1", pl[1], t0 + 6);
        check("simul_cnt", (pc[0] - bp[0]) + (pc[1] - bp[1]), 2);
        key_n = 2'b11;
        step(10);
        // staggered by one cycle
        t0 = cyc;
        key_n = 2'b10;
        step(1);
        key_n = 2'b00;
        step(10);
        check("stagger_press0", pl[0], t0 + 6);
        check("stagger_press1", pl[1], t0 + 7);
        key_n = 2'b11;
        step(10);
        // reset in the middle of a hold
        snap();
        key_n = 2'b10;
        step(18);
        rst = 1'b0;
        step(3);
        check("midrst_outs", outs(), 0);
        rst = 1'b1;
        t1 = cyc;
        step(12);
        check("midrst_no_release", rc[0] - br[0], 0);
        check("midrst_press_time", pl[0], t1 + 6);
        check("midrst_press_cnt", pc[0] - bp[0], 2);
        check("midrst_no_hold", hc[0] - bh[0], 0);
        check("midrst_pressed", int'(pressed), 1);
        key_n = 2'b11;
        step(10);
        check("exclusive", excl, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
